// File: rtl/apb_xfer_ctrl_if.sv
// apb_xfer_ctrl_if: pipeline request/response and APB bus signals of the APB transfer controller
//   req_*    : memory-stage load/store request (req_vld, req_wr, req_addr, req_wdata)
//   stall_req: pipeline stall request to the hazard unit
//   rsp_*    : one-cycle completion pulse with read data and error flag
//   busy, err_cnt : debug status
//   P*       : APB master-side bus signals
interface apb_xfer_ctrl_if;
    logic        req_vld;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_req;
    logic        rsp_vld;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    modport master (
        input  req_vld, req_wr, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
        output stall_req, rsp_vld, rsp_rdata, rsp_err, busy, err_cnt,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_vld, req_wr, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
        input  stall_req, rsp_vld, rsp_rdata, rsp_err, busy, err_cnt,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: runs one APB SETUP/ACCESS transfer per memory-stage request, stalling the pipeline meanwhile
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : apb_xfer_ctrl_if.master (request, response, status and APB signals)
//   TIMEOUT : ACCESS wait cycles tolerated without PREADY before abort (1..255)
module apb_xfer_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    apb_xfer_ctrl_if.master  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state, nxt;
    logic [7:0]  wait_cnt, err_cnt;
    logic        psel, penable, pwrite, rsp_vld, rsp_err, busy;
    logic [31:0] paddr, pwdata, rsp_rdata;
    logic        tmo, fin_err;

    assign tmo     = wait_cnt == 8'(TIMEOUT);
    assign fin_err = bus.PREADY ? bus.PSLVERR : 1'b1;

    always_comb
        nxt = state == IDLE   ? (bus.req_vld ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? ((bus.PREADY || tmo) ? DONE : ACCESS) :
                                IDLE;

    // Control outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_vld   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_cnt   <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= nxt;
            psel    <= nxt == SETUP || nxt == ACCESS;
            penable <= nxt == ACCESS;
            rsp_vld <= nxt == DONE;
            busy    <= nxt != IDLE;
            if (state == IDLE && bus.req_vld) begin
                pwrite <= bus.req_wr;
                paddr  <= bus.req_addr;
                pwdata <= bus.req_wdata;
            end
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !bus.PREADY && !tmo)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == ACCESS && nxt == DONE) begin
                rsp_rdata <= (bus.PREADY && !pwrite) ? bus.PRDATA : 32'd0;
                rsp_err   <= fin_err;
                if (fin_err && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Combinational so the request cycle itself stalls; released in DONE so the pipeline advances as DONE ends.
    assign bus.stall_req = bus.req_vld && state != DONE;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.busy      = busy;
    assign bus.err_cnt   = err_cnt;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;
endmodule
